// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_mem_pkg
// Brief    : Shared memory-map constants and DMA state encoding.
// Revision : 1.0
// ============================================================================
package gb_mem_pkg;

    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam int          OAM_LEN       = 160;
    localparam logic [15:0] REG_DMA       = 16'hFF46;
    localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    // E000-FFFF sources fold down onto the work-RAM echo, so FE maps to DE.
    function automatic logic [7:0] echo_fold(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_if
// Brief    : Simple byte-wide memory port with master/slave views.
// Revision : 1.0
// ============================================================================
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (output addr_select, output write_value, output write_enable, input read_out);
    modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_engine
// Brief    : FF46-triggered 160-byte copy from XX00-XX9F into OAM FE00-FE9F.
// Revision : 1.0
// ============================================================================
module oam_dma_engine
    import gb_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int START_DELAY  = 4
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  reg_if,
    mem_if.master dma_req,
    output logic  dma_active
);

    dma_state_t r_state;
    logic [7:0] r_src_hi;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic [3:0] r_cnt;
    logic       r_active;

    logic       w_reg_wr;
    logic [7:0] w_eff_hi;

    assign w_reg_wr = (reg_if.addr_select == REG_DMA) && reg_if.write_enable;
    assign w_eff_hi = echo_fold(r_src_hi);

    assign reg_if.read_out = (reg_if.addr_select == REG_DMA) ? r_src_hi : 8'hFF;

    // Bus outputs decode registered state only, never the CPU port.
    always_comb begin
        dma_req.addr_select  = BUS_IDLE_ADDR;
        dma_req.write_value  = 8'h00;
        dma_req.write_enable = 1'b0;
        case (r_state)
            READ:    dma_req.addr_select = {w_eff_hi, r_idx};
            WRITE: begin
                dma_req.addr_select  = OAM_BASE + {8'h00, r_idx};
                dma_req.write_value  = r_data;
                dma_req.write_enable = 1'b1;
            end
            default: dma_req.addr_select = BUS_IDLE_ADDR;
        endcase
    end

    assign dma_active = r_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_src_hi <= 8'hFF;
            r_idx    <= 8'h00;
            r_data   <= 8'h00;
            r_cnt    <= 4'd0;
            r_active <= 1'b0;
        end else if (w_reg_wr) begin
            // A trigger restarts from byte 0 whatever the engine was doing.
            r_src_hi <= reg_if.write_value;
            r_idx    <= 8'h00;
            r_active <= 1'b1;
            if (START_DELAY == 0) begin
                r_state <= READ;
                r_cnt   <= 4'(READ_LATENCY);
            end else begin
                r_state <= DELAY;
                r_cnt   <= 4'(START_DELAY);
            end
        end else begin
            case (r_state)
                DELAY: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= READ;
                        r_cnt   <= 4'(READ_LATENCY);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                READ: begin
                    if (r_cnt == 4'd0) begin
                        r_data  <= dma_req.read_out;
                        r_state <= WRITE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (r_idx == 8'(OAM_LEN - 1)) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= READ;
                        r_cnt   <= 4'(READ_LATENCY);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
